// File: rtl/ct_split_pkg.sv
// ct_split shared package: log2 helper, drop counter width and
// a default-width beat record {data, eop}.
package ct_split_pkg;

    localparam int CT_DROPCNT_W = 16;
    localparam int CT_WIDTH     = 32;

    typedef struct packed {
        logic [CT_WIDTH-1:0] data;
        logic                eop;
    } ct_beat_t;

    // Ceiling log2; a value of 1 or less gives 0.
    function automatic int CLogB2(input int value);
        int r;
        int v;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ct_split_track.sv
// ct_split_track: per-output delivery tracking for one held beat.
// Ports: clk, reset_n, i_s_valid, i_s_mask, i_ready -> o_valid, o_beat_done.
module ct_split_track
    import ct_split_pkg::*;
#(
    parameter int NO = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          i_s_valid,
    input  logic [NO-1:0] i_s_mask,
    input  logic [NO-1:0] i_ready,
    output logic [NO-1:0] o_valid,
    output logic          o_beat_done
);

    logic [NO-1:0] r_done;
    logic [NO-1:0] w_pending;

    // Outputs that still owe the held beat.
    assign w_pending   = i_s_mask & ~r_done;
    assign o_valid     = {NO{i_s_valid}} & w_pending;
    assign o_beat_done = i_s_valid && ((w_pending & ~i_ready) == '0);

    // done remembers who already took the beat so nobody gets it twice.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done <= '0;
        end else if (o_beat_done) begin
            r_done <= '0;
        end else begin
            r_done <= r_done | (o_valid & i_ready);
        end
    end

endmodule

// File: rtl/ct_split.sv
// ct_split: packet-atomic fan-out of one valid/ready/eop stream to NO outputs.
// Ports: clk, reset_n, i_data/i_valid/i_eop/i_mask -> o_ready;
//        o_valid[NO], o_data, o_eop <- i_ready[NO].
// Option CT_SPLIT_DROPCNT_EN adds o_drop_count (empty-mask packets, saturating).
module ct_split
    import ct_split_pkg::*;
#(
    parameter int NO    = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_eop,
    input  logic [NO-1:0]    i_mask,
    output logic [NO-1:0]    o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_eop,
    input  logic [NO-1:0]    i_ready
`ifdef CT_SPLIT_DROPCNT_EN
    ,
    output logic [CT_DROPCNT_W-1:0] o_drop_count
`endif
);

    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;
    logic             r_s_eop;
    logic [NO-1:0]    r_s_mask;
    logic             r_sop;
    logic             w_beat_done;
    logic             w_accept;

    ct_split_track #(
        .NO(NO)
    ) u_track (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_s_valid  (r_s_valid),
        .i_s_mask   (r_s_mask),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_beat_done(w_beat_done)
    );

    // Retiring beat frees the slot in the same cycle: no bubble.
    assign o_ready  = !r_s_valid || w_beat_done;
    assign w_accept = i_valid && o_ready;
    assign o_data   = r_s_data;
    assign o_eop    = r_s_eop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_eop   <= 1'b0;
            r_s_mask  <= '0;
            r_sop     <= 1'b1;
        end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_data  <= i_data;
            r_s_eop   <= i_eop;
            // Mask is latched once per packet, on its first beat.
            if (r_sop) begin
                r_s_mask <= i_mask;
            end
            r_sop <= i_eop;
        end else if (w_beat_done) begin
            r_s_valid <= 1'b0;
        end
    end

`ifdef CT_SPLIT_DROPCNT_EN
    logic [CT_DROPCNT_W-1:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_accept && r_sop && (i_mask == '0)
                     && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_ct_split.sv
// Bench for ct_split (NO=2, WIDTH=32): vector table, reset sequence,
// then random traffic against per-output expected-beat queues.
module tb_ct_split;
    import ct_split_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [31:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        i_eop;
    logic [1:0]  i_mask;
    logic [1:0]  o_valid;
    logic [31:0] o_data;
    logic        o_eop;
    logic [1:0]  i_ready;
`ifdef CT_SPLIT_DROPCNT_EN
    logic [15:0] o_drop_count;
`endif

    ct_split #(
        .NO(2),
        .WIDTH(32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_eop  (i_eop),
        .i_mask (i_mask),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_eop  (o_eop),
        .i_ready(i_ready)
`ifdef CT_SPLIT_DROPCNT_EN
        ,
        .o_drop_count(o_drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        vld;
        logic        eop;
        logic [1:0]  mask;
        logic [1:0]  rdy;
        logic [31:0] data;
        logic [1:0]  ev;
        logic        er;
        logic        ee;
        logic [31:0] ed;
    } vec_t;

    function automatic vec_t mk(logic vld, logic eop, logic [1:0] mask,
                                logic [1:0] rdy, logic [31:0] data,
                                logic [1:0] ev, logic er, logic ee,
                                logic [31:0] ed);
        vec_t v;
        v.vld = vld; v.eop = eop; v.mask = mask; v.rdy = rdy;
        v.data = data; v.ev = ev; v.er = er; v.ee = ee; v.ed = ed;
        return v;
    endfunction

    vec_t tbl[22];

    ct_beat_t q[2][$];

    initial begin
        ct_beat_t b;
        int       cyc;
        int       sent;
        int       bidx;
        int       plen;
        int       mdrops;
        bit       have;
        logic     msop;
        logic     er;
        logic [1:0] mmask;

        // reset state, split acceptance
        tbl[0]  = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b00, 1, 0, 32'h0);
        tbl[1]  = mk(1, 1, 2'b11, 2'b01, 32'hA, 2'b00, 1, 0, 32'h0);
        tbl[2]  = mk(0, 0, 2'b00, 2'b01, 32'h0, 2'b11, 0, 1, 32'hA);
        tbl[3]  = mk(0, 0, 2'b00, 2'b01, 32'h0, 2'b10, 0, 1, 32'hA);
        tbl[4]  = mk(0, 0, 2'b00, 2'b01, 32'h0, 2'b10, 0, 1, 32'hA);
        tbl[5]  = mk(0, 0, 2'b00, 2'b10, 32'h0, 2'b10, 1, 1, 32'hA);
        tbl[6]  = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b00, 1, 0, 32'h0);
        // back-to-back single-beat packets
        tbl[7]  = mk(1, 1, 2'b01, 2'b11, 32'hB, 2'b00, 1, 0, 32'h0);
        tbl[8]  = mk(1, 1, 2'b10, 2'b11, 32'hC, 2'b01, 1, 1, 32'hB);
        tbl[9]  = mk(1, 1, 2'b11, 2'b11, 32'hD, 2'b10, 1, 1, 32'hC);
        tbl[10] = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b11, 1, 1, 32'hD);
        tbl[11] = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b00, 1, 0, 32'h0);
        // 3-beat packet, later masks ignored
        tbl[12] = mk(1, 0, 2'b11, 2'b11, 32'hE1, 2'b00, 1, 0, 32'h0);
        tbl[13] = mk(1, 0, 2'b00, 2'b11, 32'hE2, 2'b11, 1, 0, 32'hE1);
        tbl[14] = mk(1, 1, 2'b00, 2'b11, 32'hE3, 2'b11, 1, 0, 32'hE2);
        tbl[15] = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b11, 1, 1, 32'hE3);
        tbl[16] = mk(0, 0, 2'b00, 2'b11, 32'h0, 2'b00, 1, 0, 32'h0);
        // empty-mask 4-beat packet dropped at full rate
        tbl[17] = mk(1, 0, 2'b00, 2'b11, 32'hF0, 2'b00, 1, 0, 32'h0);
        tbl[18] = mk(1, 0, 2'b11, 2'b11, 32'hF1, 2'b00, 1, 0, 32'h0);
        tbl[19] = mk(1, 0, 2'b11, 2'b00, 32'hF2, 2'b00, 1, 0, 32'h0);
        tbl[20] = mk(1, 1, 2'b01, 2'b00, 32'hF3, 2'b00, 1, 0, 32'h0);
        tbl[21] = mk(0, 0, 2'b00, 2'b00, 32'h0, 2'b00, 1, 0, 32'h0);

        reset_n = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_eop   = 1'b0;
        i_mask  = '0;
        i_ready = 2'b11;
        #3;
        chk("rst_ovalid", o_valid, 2'b00);
        chk("rst_oready", o_ready, 1'b1);
`ifdef CT_SPLIT_DROPCNT_EN
        chk("rst_dropcnt", o_drop_count, 16'd0);
`endif
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 22; i++) begin
            i_valid = tbl[i].vld;
            i_eop   = tbl[i].eop;
            i_mask  = tbl[i].mask;
            i_ready = tbl[i].rdy;
            i_data  = tbl[i].data;
            #3;
            chk($sformatf("vec%0d_ovalid", i), o_valid, tbl[i].ev);
            chk($sformatf("vec%0d_oready", i), o_ready, tbl[i].er);
            if (tbl[i].ev != 2'b00) begin
                chk($sformatf("vec%0d_data", i), o_data, tbl[i].ed);
                chk($sformatf("vec%0d_eop", i), o_eop, tbl[i].ee);
            end
            @(posedge clk);
            #1;
        end
`ifdef CT_SPLIT_DROPCNT_EN
        chk("tbl_dropcnt", o_drop_count, 16'd1);
`endif

        // async reset while a beat is held on both outputs
        i_valid = 1'b1; i_eop = 1'b0; i_mask = 2'b11;
        i_data = 32'h5A; i_ready = 2'b00;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        #2;
        chk("hold_ovalid", o_valid, 2'b11);
        chk("hold_oready", o_ready, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("arst_ovalid", o_valid, 2'b00);
        chk("arst_oready", o_ready, 1'b1);
`ifdef CT_SPLIT_DROPCNT_EN
        chk("arst_dropcnt", o_drop_count, 16'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        i_valid = 1'b1; i_eop = 1'b0; i_mask = 2'b01;
        i_data = 32'h61; i_ready = 2'b11;
        @(posedge clk);
        #1;
        i_valid = 1'b1; i_eop = 1'b1; i_mask = 2'b10; i_data = 32'h62;
        #2;
        chk("post_sop_ovalid", o_valid, 2'b01);
        chk("post_sop_data", o_data, 32'h61);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        #2;
        chk("post_b2_ovalid", o_valid, 2'b01);
        chk("post_b2_data", {o_data, o_eop}, {32'h62, 1'b1});
        @(posedge clk);
        #1;
        #2;
        chk("post_idle_ovalid", o_valid, 2'b00);
        @(posedge clk);
        #1;

        // random traffic, 1000 packets
        cyc = 0; sent = 0; bidx = 0; plen = 1; mdrops = 0;
        have = 0; msop = 1'b1; mmask = 2'b00;
        while ((sent < 1000 || have || q[0].size() != 0
                || q[1].size() != 0) && cyc < 30000) begin
            if (!have && sent < 1000 && $urandom_range(0, 3) != 0) begin
                if (bidx == 0) plen = $urandom_range(1, 4);
                i_data = $urandom;
                i_eop  = (bidx == plen - 1);
                i_mask = 2'($urandom_range(0, 3));
                have   = 1;
            end
            i_valid = have;
            i_ready = 2'($urandom_range(0, 3));
            #3;
            er = 1'b1;
            for (int j = 0; j < 2; j++)
                if (q[j].size() != 0 && !i_ready[j]) er = 1'b0;
            chk("rnd_ovalid", o_valid,
                {q[1].size() != 0, q[0].size() != 0});
            chk("rnd_oready", o_ready, er);
`ifdef CT_SPLIT_DROPCNT_EN
            chk("rnd_dropcnt", o_drop_count, 16'(mdrops));
`endif
            for (int j = 0; j < 2; j++) begin
                if (q[j].size() != 0 && i_ready[j]) begin
                    b = q[j].pop_front();
                    chk($sformatf("rnd_beat%0d", j),
                        {o_data, o_eop}, {b.data, b.eop});
                end
            end
            if (i_valid && er) begin
                if (msop) begin
                    mmask = i_mask;
                    if (i_mask == 2'b00 && mdrops < 65535) mdrops++;
                end
                b.data = i_data;
                b.eop  = i_eop;
                for (int j = 0; j < 2; j++)
                    if (mmask[j]) q[j].push_back(b);
                msop = i_eop;
                have = 0;
                if (i_eop) begin
                    bidx = 0;
                    sent++;
                end else begin
                    bidx++;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_sent", sent, 1000);
        chk("rnd_q0_empty", q[0].size(), 0);
        chk("rnd_q1_empty", q[1].size(), 0);
`ifdef CT_SPLIT_DROPCNT_EN
        chk("rnd_dropcnt_end", o_drop_count, 16'(mdrops));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
